rv32i_icache_loader: RTL and testbench

//  Downstream of the UDP receive parser. Takes the 32-bit program words it emits
//  (data_o / data_o_valid, one pulse per 4 payload bytes) and writes them to

---
 rtl/rv32i_icache_loader_if.sv | 27 ++
 rtl/rv32i_icache_loader.sv | 153 +++++++++++++++
 tb/tb_rv32i_icache_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_icache_loader_if.sv
// Bundles the receive-parser word stream, the instruction-memory write port and
// the load status lines shared by the icache loader and whatever sits around it.
interface rv32i_icache_loader_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]     data_i;
    logic            data_i_valid;
    logic            rx_finish_i;
    logic            imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]     imem_wdata;
    logic            imem_ready;
    logic            core_hold;
    logic            load_done;
    logic [ADDR_W:0] word_count;
    logic            err_ovf;

    modport master (
        input  data_i, data_i_valid, rx_finish_i, imem_ready,
        output imem_we, imem_addr, imem_wdata, core_hold, load_done, word_count, err_ovf
    );

    modport slave (
        output data_i, data_i_valid, rx_finish_i, imem_ready,
        input  imem_we, imem_addr, imem_wdata, core_hold, load_done, word_count, err_ovf
    );
endinterface

// File: rtl/rv32i_icache_loader.sv
// Streams parser words through a small show-ahead FIFO into consecutive
// instruction-memory addresses, holding the core in reset while a load runs.
module rv32i_icache_loader #(
    parameter int ADDR_W  = 10,
    parameter int FIFO_AW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_icache_loader_if.master bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_fifo [DEPTH];
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_mem_full;
    logic                r_err_ovf;

    logic w_empty;
    logic w_full;
    logic w_we;
    logic w_hold;
    logic w_done;
    logic w_active;
    logic w_start;
    logic w_push_req;
    logic w_push;
    logic w_commit;
    logic w_discard;
    logic w_pop;
    logic w_drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    assign w_active   = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_start    = (r_state == S_IDLE) && bus.data_i_valid;
    assign w_push_req = bus.data_i_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_commit   = w_we && bus.imem_ready;
    // Once memory is full, queued words are still popped so the drain can finish.
    assign w_discard  = w_active && !w_empty && r_mem_full;
    assign w_pop      = w_commit || w_discard;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_hold       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.data_i_valid) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_hold = 1'b1;
                w_we   = !w_empty && !r_mem_full;
                if (bus.rx_finish_i) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_hold = 1'b1;
                w_we   = !w_empty && !r_mem_full;
                if (w_empty) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_hold       = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= bus.data_i;
        end
    end

    // The address sticks at the top word after the last slot is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_mem_full <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_start) begin
                r_addr     <= '0;
                r_count    <= '0;
                r_mem_full <= 1'b0;
                r_err_ovf  <= 1'b0;
            end else begin
                if (w_commit) begin
                    r_count <= r_count + 1'b1;
                    if (r_addr == '1) begin
                        r_mem_full <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                if (w_drop || w_discard) begin
                    r_err_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_we    = w_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_fifo[r_rd_ptr[FIFO_AW-1:0]];
    assign bus.core_hold  = w_hold;
    assign bus.load_done  = w_done;
    assign bus.word_count = r_count;
    assign bus.err_ovf    = r_err_ovf;
endmodule

// File: tb/tb_rv32i_icache_loader.sv
// Directed bench for the icache loader: a per-cycle vector table for the normal,
// back-pressure and same-cycle cases, plus hand sequences for reset and memory-full.
module tb_rv32i_icache_loader;
    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    rv32i_icache_loader_if #(.ADDR_W(10)) busA ();
    rv32i_icache_loader_if #(.ADDR_W(2))  busB ();

    rv32i_icache_loader #(.ADDR_W(10), .FIFO_AW(2)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    rv32i_icache_loader #(.ADDR_W(2), .FIFO_AW(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    // One row describes `rep` identical cycles: inputs held, outputs expected.
    typedef struct {
        int          rep;
        logic        valid;
        logic [31:0] data;
        logic        fin;
        logic        ready;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        hold;
        logic        done;
        logic [15:0] cnt;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t seqReset[$];
    vec_t seqRestart[$];
    vec_t seqMemFull[$];

    function automatic vec_t mk(input int rep, input logic valid, input logic [31:0] data,
                                input logic fin, input logic ready, input logic we,
                                input int addr, input logic [31:0] wdata, input logic hold,
                                input logic done, input int cnt, input logic ovf);
        vec_t v;
        v.rep = rep;   v.valid = valid; v.data = data;   v.fin = fin;
        v.ready = ready; v.we = we;     v.addr = 16'(addr); v.wdata = wdata;
        v.hold = hold; v.done = done;   v.cnt = 16'(cnt); v.ovf = ovf;
        return v;
    endfunction

    task automatic checkVal(input string name, input int step,
                            input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int sel);
        busA.data_i = 32'h0; busA.data_i_valid = 1'b0; busA.rx_finish_i = 1'b0; busA.imem_ready = 1'b0;
        busB.data_i = 32'h0; busB.data_i_valid = 1'b0; busB.rx_finish_i = 1'b0; busB.imem_ready = 1'b0;
        if (sel == 0) begin
            busA.data_i = v.data; busA.data_i_valid = v.valid;
            busA.rx_finish_i = v.fin; busA.imem_ready = v.ready;
        end else begin
            busB.data_i = v.data; busB.data_i_valid = v.valid;
            busB.rx_finish_i = v.fin; busB.imem_ready = v.ready;
        end
    endtask

    task automatic checkOutput(input vec_t v, input int sel, input string tag, input int step);
        logic        we, hold, done, ovf;
        logic [15:0] addr, cnt;
        logic [31:0] wdata;
        if (sel == 0) begin
            we = busA.imem_we; hold = busA.core_hold; done = busA.load_done; ovf = busA.err_ovf;
            addr = 16'(busA.imem_addr); cnt = 16'(busA.word_count); wdata = busA.imem_wdata;
        end else begin
            we = busB.imem_we; hold = busB.core_hold; done = busB.load_done; ovf = busB.err_ovf;
            addr = 16'(busB.imem_addr); cnt = 16'(busB.word_count); wdata = busB.imem_wdata;
        end
        checkVal({tag, " imem_we"}, step, 32'(we), 32'(v.we));
        checkVal({tag, " imem_addr"}, step, 32'(addr), 32'(v.addr));
        checkVal({tag, " core_hold"}, step, 32'(hold), 32'(v.hold));
        checkVal({tag, " load_done"}, step, 32'(done), 32'(v.done));
        checkVal({tag, " word_count"}, step, 32'(cnt), 32'(v.cnt));
        checkVal({tag, " err_ovf"}, step, 32'(ovf), 32'(v.ovf));
        if (v.we) begin
            checkVal({tag, " imem_wdata"}, step, wdata, v.wdata);
        end
    endtask

    task automatic runRow(input vec_t v, input int sel, input string tag, input int step);
        for (int r = 0; r < v.rep; r++) begin
            @(negedge clk);
            applyStimulus(v, sel);
            #1;
            checkOutput(v, sel, tag, step);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, " A imem_we"}, 0, 32'(busA.imem_we), 32'h0);
        checkVal({tag, " A imem_addr"}, 0, 32'(busA.imem_addr), 32'h0);
        checkVal({tag, " A core_hold"}, 0, 32'(busA.core_hold), 32'h0);
        checkVal({tag, " A load_done"}, 0, 32'(busA.load_done), 32'h0);
        checkVal({tag, " A word_count"}, 0, 32'(busA.word_count), 32'h0);
        checkVal({tag, " A err_ovf"}, 0, 32'(busA.err_ovf), 32'h0);
        checkVal({tag, " B imem_addr"}, 0, 32'(busB.imem_addr), 32'h0);
        checkVal({tag, " B word_count"}, 0, 32'(busB.word_count), 32'h0);
    endtask

    initial begin
        logic [31:0] w1 [4];
        vec_t idle;
        w1 = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

        // Four words with 8-cycle gaps, memory always ready.
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 1, w1[i], 0, 1, 0, i, 0, (i != 0), 0, i, 0));
            tbl.push_back(mk(1, 0, 0, 0, 1, 1, i, w1[i], 1, 0, i, 0));
            tbl.push_back(mk(7, 0, 0, 0, 1, 0, i + 1, 0, 1, 0, i + 1, 0));
        end
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 4, 0, 1, 0, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 1, 0, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 1, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 4, 0));

        // Memory stalled for 20 cycles while six words arrive back to back.
        tbl.push_back(mk(1, 1, 32'hA0000000, 0, 0, 0, 4, 0, 0, 0, 4, 0));
        for (int i = 1; i < 5; i++)
            tbl.push_back(mk(1, 1, 32'hA0000000 + i, 0, 0, 1, 0, 32'hA0000000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA0000005, 0, 0, 1, 0, 32'hA0000000, 1, 0, 0, 1));
        tbl.push_back(mk(14, 0, 0, 0, 0, 1, 0, 32'hA0000000, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 0, 0, 1, 1, i, 32'hA0000000 + i, 1, 0, i, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 4, 0, 1, 0, 4, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 1, 0, 4, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 1, 1, 4, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 4, 1));

        // Push into a full FIFO in the same cycle as a committing write.
        tbl.push_back(mk(1, 1, 32'hE0000000, 0, 0, 0, 4, 0, 0, 0, 4, 1));
        for (int i = 1; i < 4; i++)
            tbl.push_back(mk(1, 1, 32'hE0000000 + i, 0, 0, 1, 0, 32'hE0000000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hE0000004, 0, 1, 1, 0, 32'hE0000000, 1, 0, 0, 0));
        for (int i = 1; i < 5; i++)
            tbl.push_back(mk(1, 0, 0, 0, 1, 1, i, 32'hE0000000 + i, 1, 0, i, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 5, 0, 1, 0, 5, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 5, 0, 1, 0, 5, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 5, 0, 1, 1, 5, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 5, 0));

        // Last word arrives together with rx_finish.
        tbl.push_back(mk(1, 1, 32'h0000006F, 0, 1, 0, 5, 0, 0, 0, 5, 0));
        tbl.push_back(mk(1, 1, 32'h00000073, 1, 1, 1, 0, 32'h0000006F, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h00000073, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 0, 1, 1, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 2, 0));

        // Reset mid-load with two words still queued.
        seqReset.push_back(mk(1, 1, 32'h11110000, 0, 0, 0, 2, 0, 0, 0, 2, 0));
        seqReset.push_back(mk(1, 1, 32'h11110001, 0, 0, 1, 0, 32'h11110000, 1, 0, 0, 0));
        seqReset.push_back(mk(1, 1, 32'h11110002, 0, 0, 1, 0, 32'h11110000, 1, 0, 0, 0));
        seqReset.push_back(mk(1, 0, 0, 0, 1, 1, 0, 32'h11110000, 1, 0, 0, 0));
        seqReset.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h11110001, 1, 0, 1, 0));

        seqRestart.push_back(mk(1, 1, 32'h22220000, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        seqRestart.push_back(mk(1, 0, 0, 0, 1, 1, 0, 32'h22220000, 1, 0, 0, 0));
        seqRestart.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0));
        seqRestart.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0));
        seqRestart.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0));
        seqRestart.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0));
        seqRestart.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));

        // Four-word memory receiving five words: the fifth is dropped at the top address.
        seqMemFull.push_back(mk(1, 1, 32'h0000B000, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 5; i++)
            seqMemFull.push_back(mk(1, 1, 32'h0000B000 + i, 0, 1, 1, i - 1, 32'h0000B000 + i - 1, 1, 0, i - 1, 0));
        seqMemFull.push_back(mk(1, 0, 0, 0, 1, 0, 3, 0, 1, 0, 4, 0));
        seqMemFull.push_back(mk(1, 0, 0, 1, 1, 0, 3, 0, 1, 0, 4, 1));
        seqMemFull.push_back(mk(1, 0, 0, 0, 1, 0, 3, 0, 1, 0, 4, 1));
        seqMemFull.push_back(mk(1, 0, 0, 0, 1, 0, 3, 0, 1, 1, 4, 1));
        seqMemFull.push_back(mk(1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 4, 1));

        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(idle, 0);
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            runRow(tbl[i], 0, "table", i);

        for (int i = 0; i < seqReset.size(); i++)
            runRow(seqReset[i], 0, "preReset", i);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midLoadReset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < seqRestart.size(); i++)
            runRow(seqRestart[i], 0, "restart", i);

        for (int i = 0; i < seqMemFull.size(); i++)
            runRow(seqMemFull[i], 1, "memFull", i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
